// File: rtl/obi_demux_1_to_n.sv
// obi_demux_1_to_n: one OBI controller fanned out to NUM_PORTS OBI slaves by
// address decode. Up to MAX_OUTSTANDING reads are tracked in a small FIFO of
// port selects so that responses are routed back strictly in order. Accesses
// that hit no address window are granted locally; unmapped reads are answered
// with ERR_RDATA.
module obi_demux_1_to_n #(
  parameter int unsigned               NUM_PORTS       = 4,
  parameter int unsigned               MAX_OUTSTANDING = 4,
  parameter logic [NUM_PORTS*32-1:0]   PORT_BASE_ADDRS = {NUM_PORTS{32'h0}},
  parameter logic [NUM_PORTS*32-1:0]   PORT_END_ADDRS  = {NUM_PORTS{32'h0}},
  parameter logic [31:0]               ERR_RDATA       = 32'hDEAD_BEEF
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   ctrl_req_i,
  output logic                                   ctrl_gnt_o,
  input  logic [31:0]                            ctrl_addr_i,
  input  logic                                   ctrl_we_i,
  input  logic [3:0]                             ctrl_be_i,
  input  logic [31:0]                            ctrl_wdata_i,
  output logic                                   ctrl_rvalid_o,
  output logic [31:0]                            ctrl_rdata_o,
  output logic [NUM_PORTS-1:0]                   port_req_o,
  input  logic [NUM_PORTS-1:0]                   port_gnt_i,
  output logic [NUM_PORTS*32-1:0]                port_addr_o,
  output logic [NUM_PORTS-1:0]                   port_we_o,
  output logic [NUM_PORTS*4-1:0]                 port_be_o,
  output logic [NUM_PORTS*32-1:0]                port_wdata_o,
  input  logic [NUM_PORTS-1:0]                   port_rvalid_i,
  input  logic [NUM_PORTS*32-1:0]                port_rdata_i,
  output logic                                   illegal_access_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  // Select encoding: 0..NUM_PORTS-1 are slave ports, NUM_PORTS means "no match".
  localparam int unsigned SEL_W = $clog2(NUM_PORTS + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(NUM_PORTS);

  logic [SEL_W-1:0] sel;
  logic             sel_mapped;
  logic             sel_gnt;
  logic             stall;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [SEL_W-1:0] head_sel;

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [SEL_W-1:0] tail_sel_q;
  logic [SEL_W-1:0] fifo_q [MAX_OUTSTANDING];

  // Pointer increment wrapping at MAX_OUTSTANDING so odd depths work too.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address-phase fields are broadcast; only the request is steered.
  assign port_addr_o  = {NUM_PORTS{ctrl_addr_i}};
  assign port_we_o    = {NUM_PORTS{ctrl_we_i}};
  assign port_be_o    = {NUM_PORTS{ctrl_be_i}};
  assign port_wdata_o = {NUM_PORTS{ctrl_wdata_i}};

  // Address decode; scanning downwards lets the lowest matching window win.
  always_comb begin
    sel = SEL_ERR;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if ((ctrl_addr_i >= PORT_BASE_ADDRS[32*i +: 32]) &&
          (ctrl_addr_i <= PORT_END_ADDRS[32*i +: 32])) begin
        sel = SEL_W'(i);
      end
    end
  end

  assign sel_mapped       = (sel != SEL_ERR);
  assign illegal_access_o = ctrl_req_i && !sel_mapped;

  // Reads stall when the tracker is full, or when they would target a different
  // slave than the youngest outstanding read (responses could otherwise overtake).
  // Both terms use the registered count, so a pop in this cycle does not help.
  always_comb begin
    stall = !ctrl_we_i &&
            ((count_q == CNT_W'(MAX_OUTSTANDING)) ||
             ((count_q != '0) && (sel != tail_sel_q)));
  end

  // Request steering and grant selection for the decoded port.
  always_comb begin
    port_req_o = '0;
    sel_gnt    = 1'b0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (sel == SEL_W'(i)) begin
        port_req_o[i] = ctrl_req_i && !stall;
        sel_gnt       = port_gnt_i[i];
      end
    end
    if (sel_mapped) begin
      ctrl_gnt_o = sel_gnt && !stall;
    end else begin
      ctrl_gnt_o = ctrl_req_i && !stall;
    end
  end

  assign push       = ctrl_req_i && ctrl_gnt_o && !ctrl_we_i;
  assign fifo_empty = (count_q == '0);
  assign head_sel   = fifo_q[rd_ptr_q];

  // Response routing from the FIFO head; everything else on port_rvalid_i is dropped.
  always_comb begin
    ctrl_rvalid_o = 1'b0;
    ctrl_rdata_o  = '0;
    if (!fifo_empty) begin
      if (head_sel == SEL_ERR) begin
        ctrl_rvalid_o = 1'b1;
        ctrl_rdata_o  = ERR_RDATA;
      end else begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
          if (head_sel == SEL_W'(i)) begin
            ctrl_rvalid_o = port_rvalid_i[i];
            ctrl_rdata_o  = port_rdata_i[32*i +: 32];
          end
        end
      end
    end
  end

  assign pop           = ctrl_rvalid_o;
  assign outstanding_o = count_q;

  // Tracker control state: occupancy, pointers and the youngest pushed select.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tail_sel_q <= SEL_ERR;
    end else begin
      if (push) begin
        wr_ptr_q   <= ptr_next(wr_ptr_q);
        tail_sel_q <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Select storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule
